rle_compressor: RTL and testbench

Streaming run-length encoder, inverse of the image decompression path. Consumes a binary image frame as 16-bit pixel words, MSB first. Pixel 0 of the frame is image bit IMG_BITS-1. Emits 16-bit run words: bit15 = pixel value, bits14:0 = run length (1..MAX_RUN). The run words are written to the compressed data store that the decompressor reads back.

---
 rtl/rle_pkg.sv | 21 ++
 rtl/rle_word_unpacker.sv | 37 +++
 rtl/rle_compressor.sv | 188 ++++++++++++++++++
 tb/tb_rle_compressor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared constants, FSM state encoding and run-word layout for the run-length encoder.
package rle_pkg;
    localparam int IN_W    = 16;
    localparam int CNT_W   = 15;
    localparam int MAX_RUN = (1 << CNT_W) - 1;
    localparam int BL_W    = $clog2(IN_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        EMIT  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic             pix;
        logic [CNT_W-1:0] len;
    } run_word_t;
endpackage

// File: rtl/rle_word_unpacker.sv
// Serialises one input pixel word MSB first; pix is the current pixel, last marks its final bit.
module rle_word_unpacker
    import rle_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [IN_W-1:0] data,
    input  logic            shift,
    output logic            pix,
    output logic            last,
    output logic            empty
);
    logic [IN_W-1:0] shreg_r;
    logic [BL_W-1:0] bits_left_r;

    // Shift register and remaining-bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r     <= {IN_W{1'b0}};
            bits_left_r <= {BL_W{1'b0}};
        end else if (load) begin
            shreg_r     <= data;
            bits_left_r <= BL_W'(IN_W);
        end else if (shift && (bits_left_r != {BL_W{1'b0}})) begin
            shreg_r     <= {shreg_r[IN_W-2:0], 1'b0};
            bits_left_r <= bits_left_r - BL_W'(1);
        end else begin
            shreg_r     <= shreg_r;
            bits_left_r <= bits_left_r;
        end
    end

    assign pix   = shreg_r[IN_W-1];
    assign last  = (bits_left_r == BL_W'(1));
    assign empty = (bits_left_r == {BL_W{1'b0}});
endmodule

// File: rtl/rle_compressor.sv
// Streaming run-length encoder: pixel words in, {run_bit, run_len} words out.
// Optional RLE_STATS_EN adds word_count and overflow outputs.
module rle_compressor
    import rle_pkg::*;
#(
    parameter int IMG_BITS = 16384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_word,
    output logic            busy,
    output logic            frame_done
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]     word_count,
    output logic            overflow
`endif
);
    localparam int PL_W = $clog2(IMG_BITS + 1);

    state_t           state_r;
    logic [PL_W-1:0]  pix_left_r;
    logic             run_bit_r;
    logic [CNT_W-1:0] run_len_r;
    run_word_t        out_r;
    logic             in_ready_r, out_valid_r, busy_r, frame_done_r;

    logic             load_s, shift_s, pix_s, last_s, empty_s;
    logic             next_bit_s, term_s;
    logic [CNT_W-1:0] next_len_s;

    assign load_s  = (state_r == LOAD) && in_valid && in_ready_r;
    assign shift_s = (state_r == SCAN);

    rle_word_unpacker u_unpacker (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .data  (in_data),
        .shift (shift_s),
        .pix   (pix_s),
        .last  (last_s),
        .empty (empty_s)
    );

    // Run update for the pixel consumed this cycle; term_s closes the current run
    always_comb begin
        next_bit_s = pix_s;
        next_len_s = CNT_W'(1);
        term_s     = 1'b0;
        if (run_len_r == {CNT_W{1'b0}}) begin
            next_bit_s = pix_s;
            next_len_s = CNT_W'(1);
        end else if ((pix_s == run_bit_r) && (run_len_r < CNT_W'(MAX_RUN))) begin
            next_bit_s = run_bit_r;
            next_len_s = run_len_r + CNT_W'(1);
        end else begin
            term_s = 1'b1;
        end
    end

    // Frame control FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            pix_left_r   <= {PL_W{1'b0}};
            run_bit_r    <= 1'b0;
            run_len_r    <= {CNT_W{1'b0}};
            out_r        <= '{pix: 1'b0, len: {CNT_W{1'b0}}};
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pix_left_r <= PL_W'(IMG_BITS);
                        run_bit_r  <= 1'b0;
                        run_len_r  <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_s) begin
                        in_ready_r <= 1'b0;
                        state_r    <= SCAN;
                    end
                end
                SCAN: begin
                    pix_left_r <= pix_left_r - PL_W'(1);
                    run_bit_r  <= next_bit_s;
                    run_len_r  <= next_len_s;
                    if (term_s) begin
                        out_r.pix   <= run_bit_r;
                        out_r.len   <= run_len_r;
                        out_valid_r <= 1'b1;
                        state_r     <= EMIT;
                    end else if (pix_left_r == PL_W'(1)) begin
                        // Last pixel of the frame: the final run is presented directly
                        out_r.pix   <= next_bit_s;
                        out_r.len   <= next_len_s;
                        out_valid_r <= 1'b1;
                        state_r     <= FLUSH;
                    end else if (last_s) begin
                        in_ready_r <= 1'b1;
                        state_r    <= LOAD;
                    end else begin
                        state_r <= SCAN;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (pix_left_r == {PL_W{1'b0}}) begin
                            out_r.pix <= run_bit_r;
                            out_r.len <= run_len_r;
                            state_r   <= FLUSH;
                        end else if (empty_s) begin
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= LOAD;
                        end else begin
                            out_valid_r <= 1'b0;
                            state_r     <= SCAN;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        out_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_word   = out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

`ifdef RLE_STATS_EN
    logic [15:0] word_count_r;
    logic        overflow_r;

    // Per-frame count of run-word handshakes with sticky wrap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_r <= 16'h0000;
            overflow_r   <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            word_count_r <= 16'h0000;
            overflow_r   <= 1'b0;
        end else if (out_valid_r && out_ready) begin
            word_count_r <= word_count_r + 16'h0001;
            overflow_r   <= overflow_r | (word_count_r == 16'hFFFF);
        end else begin
            word_count_r <= word_count_r;
            overflow_r   <= overflow_r;
        end
    end

    assign word_count = word_count_r;
    assign overflow   = overflow_r;
`endif
endmodule

// File: tb/tb_rle_compressor.sv
// Self-checking bench for rle_compressor: directed frame table, random stalled frame, mid-frame reset.
module tb_rle_compressor;
    localparam int IMG_BITS  = 4096;
    localparam int NW        = IMG_BITS / 16;
    localparam int MAXR      = 32767;
    localparam int CYC_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy, frame_done;
    logic [15:0] out_word;
`ifdef RLE_STATS_EN
    logic [15:0] word_count;
    logic        overflow;
`endif

    rle_compressor #(.IMG_BITS(IMG_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef RLE_STATS_EN
        ,
        .word_count (word_count),
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] first_w;
        logic [15:0] rest_w;
        int          exp_n;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] frame [NW];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;
    bit          done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] got_at(input int i);
        if (got_q.size() > i) return got_q[i];
        else return 16'hxxxx;
    endfunction

    // Runs of the frame bitmap, split at MAXR
    task automatic build_model();
        int   len = 0;
        logic cur = 1'b0;
        logic p;
        exp_q.delete();
        for (int i = 0; i < IMG_BITS; i++) begin
            p = frame[i / 16][15 - (i % 16)];
            if (len > 0 && (p != cur || len == MAXR)) begin
                exp_q.push_back({cur, 15'(len)});
                len = 0;
            end
            if (len == 0) cur = p;
            len++;
        end
        exp_q.push_back({cur, 15'(len)});
    endtask

    task automatic compare_frame(input string tag);
        int n, bits = 0, mism = 0;
        logic [15:0] w;
        build_model();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
            if (got_q[i] !== exp_q[i]) break;
        end
        foreach (got_q[i]) begin
            w = got_q[i];
            for (int k = 0; k < int'(w[14:0]); k++) begin
                if (bits < IMG_BITS && frame[bits / 16][15 - (bits % 16)] !== w[15]) mism++;
                bits++;
            end
        end
        check({tag, "_decode_len"}, bits, IMG_BITS);
        check({tag, "_decode_bits"}, mism, 0);
    endtask

    task automatic run_frame(input bit rnd, input int abort_after, output bit seen);
        int          wi = 0, cyc = 0, stall_left = 0, stall_idx = -1;
        bit          holding = 1'b0;
        logic [15:0] held = 16'h0000;
        seen = 1'b0;
        got_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on_start", busy, 1);
        while (!seen && cyc < CYC_LIMIT) begin
            if (holding) begin
                check("stall_valid", out_valid, 1);
                check("stall_word", out_word, held);
                check("stall_in_ready", in_ready, 0);
                holding = 1'b0;
            end
            if (frame_done) begin
                seen = 1'b1;
                check("busy_at_done", busy, 0);
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (rnd && stall_left == 0 && stall_idx != got_q.size() && got_q.size() % 37 == 5) begin
                        stall_left = 10;
                        stall_idx  = got_q.size();
                        stall_cnt++;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        holding = 1'b1;
                        held    = out_word;
                    end else begin
                        got_q.push_back(out_word);
                    end
                end
                in_valid = (wi < NW) && (!rnd || $urandom_range(0, 3) != 0);
                in_data  = (wi < NW) ? frame[wi] : 16'h0000;
                if (in_valid && in_ready) wi++;
                start = rnd && (cyc == 50);
                if (abort_after > 0 && wi >= abort_after) return;
                @(negedge clk);
                cyc++;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!seen) check("frame_done_timeout", 0, 1);
        else begin
            @(negedge clk);
            check("frame_done_pulse", frame_done, 0);
        end
    endtask

    initial begin
        vecs[0] = '{"zero",      16'h0000, 16'h0000, 1,        16'h1000, 16'h0000};
        vecs[1] = '{"ones",      16'hFFFF, 16'hFFFF, 1,        16'h9000, 16'h0000};
        vecs[2] = '{"ffff_zero", 16'hFFFF, 16'h0000, 2,        16'h8010, 16'h0FF0};
        vecs[3] = '{"zero_ffff", 16'h0000, 16'hFFFF, 2,        16'h0010, 16'h8FF0};
        vecs[4] = '{"alt_aaaa",  16'hAAAA, 16'hAAAA, IMG_BITS, 16'h8001, 16'h0001};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_word", out_word, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            frame[0] = vecs[v].first_w;
            for (int i = 1; i < NW; i++) frame[i] = vecs[v].rest_w;
            run_frame(1'b0, 0, done_seen);
            check({vecs[v].name, "_done"}, done_seen, 1);
            check({vecs[v].name, "_n"}, got_q.size(), vecs[v].exp_n);
            check({vecs[v].name, "_w0"}, got_at(0), vecs[v].exp0);
            if (vecs[v].exp_n > 1) check({vecs[v].name, "_w1"}, got_at(1), vecs[v].exp1);
            compare_frame(vecs[v].name);
        end

        // Random frame mixing long runs and noise, with output stalls and a start pulse while busy
        for (int i = 0; i < NW; i++) begin
            case ($urandom_range(0, 2))
                0:       frame[i] = 16'h0000;
                1:       frame[i] = 16'hFFFF;
                default: frame[i] = 16'($urandom);
            endcase
        end
        run_frame(1'b1, 0, done_seen);
        check("rand_done", done_seen, 1);
        check("rand_stalls_seen", (stall_cnt > 0), 1);
        compare_frame("rand");

        // Reset in the middle of a frame
        for (int i = 0; i < NW; i++) frame[i] = 16'($urandom);
        run_frame(1'b0, 100, done_seen);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_out_word", out_word, 16'h0000);
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NW; i++) frame[i] = 16'h0000;
        run_frame(1'b0, 0, done_seen);
        check("post_rst_done", done_seen, 1);
        check("post_rst_n", got_q.size(), 1);
        check("post_rst_w0", got_at(0), 16'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
